s27_bist_ctrl: RTL
==================

// Module: s27_bist_ctrl
// PURPOSE
//  Built-in self-test driver/checker for the s27 sequential benchmark core.
//  - Drives s27 primary inputs G0..G3 from an LFSR.
//  - Compacts the s27 primary output G17 into a MISR.
//  - Compares the final signature against a golden value and reports pass/fail.
//  - Sits beside s27 on the same clock CK; it is the stimulus/response end of the s27 I/O interface.
// PARAMETERS
//  PATTERNS     255      number of pseudo-random vectors applied in RUN (0..65535)
//  INIT_CYCLES  4        cycles of INIT_VEC applied before RUN to flush s27 state (0..255)
//  INIT_VEC     4'b0000  {G3,G2,G1,G0} held during INIT
//  LFSR_SEED    8'h01    LFSR load value on start; 8'h00 is substituted by 8'h01
//  GOLDEN       16'h0000 expected MISR signature at end of RUN
// PORTS
//  CK         in   1   single clock, rising edge
//  RST        in   1   asynchronous, active-high reset
//  START      in   1   1-cycle request; honoured only in IDLE or DONE
//  G0..G3     out  1   s27 primary inputs (G0=vec[0] .. G3=vec[3])
//  G17        in   1   s27 primary output, sampled every RUN cycle
//  BUSY       out  1   high in INIT, RUN, COMPARE
//  DONE       out  1   high in DONE, held until the next accepted START
//  PASS       out  1   signature==GOLDEN, valid only while DONE=1
//  SIGNATURE  out  16  live MISR contents
// BEHAVIOUR
//  Reset (async, RST=1): state=IDLE; G0..G3=0; BUSY=0; DONE=0; PASS=0; SIGNATURE=0;
//    LFSR=LFSR_SEED; cycle counter=0. RST mid-test aborts immediately and no result is reported.
//  FSM states: IDLE, INIT, RUN, COMPARE, DONE.
//   IDLE/DONE --START--> INIT, or RUN if INIT_CYCLES==0, or COMPARE if both counts are 0.
//     On the accepting edge: MISR<=0, LFSR<=seed, counter<=0, DONE<=0, PASS<=0.
//   INIT: vector=INIT_VEC for exactly INIT_CYCLES cycles; G17 is ignored; then RUN (or COMPARE if PATTERNS==0).
//   RUN: vector=LFSR[3:0] for exactly PATTERNS cycles. On each rising edge:
//     - MISR absorbs G17, which is combinational from the vector presented that cycle.
//     - The LFSR then advances.
//     After the last pattern -> COMPARE.
//   COMPARE: one cycle; PASS<=(MISR==GOLDEN); -> DONE. Vector returns to 0.
//   DONE: outputs held and vector=0; START re-arms with no intervening IDLE.
//  START while BUSY is ignored; it is not queued.
//  Registered outputs: G0..G3 change only on CK edges, so there is no combinational path START->G*.
//  LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
//    Period is 255; after 255 steps it repeats, which is not an error.
//  MISR: 16-bit, x^16+x^12+x^5+1, serial input.
//    fb = misr[15]^G17; next = {misr[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
//  Counter: 16 bits, wraps only via reload on START; terminal compare is ==PATTERNS-1 (or INIT_CYCLES-1).
//  Latency: START edge -> DONE = INIT_CYCLES+PATTERNS+2 cycles.
// STRUCTURE
//  Package s27_bist_pkg holds:
//    - state enum (IDLE,INIT,RUN,COMPARE,DONE)
//    - LFSR_TAPS=8'hB8, MISR_POLY=16'h1021
//    - functions lfsr_next() and misr_next()
//  One sub-module: s27_bist_misr (16-bit serial signature register with clear and enable).
//  Top = FSM + counter + LFSR + output vector register + s27_bist_misr.
// TESTING
//  Bench instantiates s27 driven by this block; a behavioural model computes the expected signature.
//  1 Defaults, golden from model, START pulse:
//      BUSY high for 4+255+1 cycles, DONE and PASS=1 at edge 261; G* match LFSR model each RUN cycle.
//  2 GOLDEN off by one bit:
//      DONE=1, PASS=0, SIGNATURE equals the model value.
//  3 START every cycle while BUSY:
//      run length unchanged; a START in DONE restarts and yields an identical SIGNATURE.
//  4 RST asserted at RUN cycle 100, released, then START:
//      all outputs 0 during reset; the second run matches test 1 exactly.
//  5 PATTERNS=0, INIT_CYCLES=0, START:
//      COMPARE on the next cycle, DONE 2 cycles after START, SIGNATURE=0, PASS=(GOLDEN==0).
//  6 LFSR_SEED=8'h00:
//      vector sequence identical to seed 8'h01; the LFSR never reaches 0 during 255 RUN cycles.

Source files
------------

// File: rtl/s27_bist_pkg.sv
// Shared types and polynomial helpers for the s27 BIST driver/checker.
package s27_bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_RUN,
      ST_COMPARE,
      ST_DONE
   } state_t;

   localparam logic [7:0]  LFSR_TAPS = 8'hB8;
   localparam logic [15:0] MISR_POLY = 16'h1021;

   // Fibonacci step for x^8+x^6+x^5+x^4+1: taps on bits 7,5,4,3.
   function automatic logic [7:0] lfsr_next(input logic [7:0] lfsr);
      return {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
   endfunction

   function automatic logic [15:0] misr_next(input logic [15:0] misr, input logic din);
      return {misr[14:0], 1'b0} ^ ((misr[15] ^ din) ? MISR_POLY : 16'h0000);
   endfunction

endpackage

// File: rtl/s27_bist_misr.sv
// 16-bit serial-input signature register; clear has priority over enable.
module s27_bist_misr
   import s27_bist_pkg::*;
(
   input  logic        clk_sys,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] sig
);

   logic [15:0] sig_q;
   logic [15:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (clr) begin
         sig_d = 16'h0000;
      end else if (en) begin
         sig_d = misr_next(sig_q, din);
      end
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         sig_q <= 16'h0000;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST controller for s27: LFSR stimulus on G0..G3, MISR compaction of G17,
// signature compare against GOLDEN.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ST_IDLE    | after reset, waiting for START
//   ST_INIT    | INIT_VEC held for INIT_CYCLES cycles, G17 ignored
//   ST_RUN     | LFSR vector applied, G17 absorbed, PATTERNS cycles
//   ST_COMPARE | one cycle, signature compared against GOLDEN
//   ST_DONE    | result held, START re-arms
module s27_bist_ctrl
   import s27_bist_pkg::*;
#(
   parameter int          PATTERNS    = 255,
   parameter int          INIT_CYCLES = 4,
   parameter logic [3:0]  INIT_VEC    = 4'b0000,
   parameter logic [7:0]  LFSR_SEED   = 8'h01,
   parameter logic [15:0] GOLDEN      = 16'h0000
)
(
   input  logic        CK,
   input  logic        RST,
   input  logic        START,
   output logic        G0,
   output logic        G1,
   output logic        G2,
   output logic        G3,
   input  logic        G17,
   output logic        BUSY,
   output logic        DONE,
   output logic        PASS,
   output logic [15:0] SIGNATURE
);

   // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
   localparam logic [7:0]  SEED_EFF  = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
   localparam logic [15:0] PAT_LAST  = 16'(PATTERNS - 1);
   localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  lfsr_q, lfsr_d;
   logic [3:0]  vec_q, vec_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        misr_clr;
   logic        misr_en;
   logic [15:0] misr_sig;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      lfsr_d   = lfsr_q;
      vec_d    = vec_q;
      done_d   = done_q;
      pass_d   = pass_q;
      misr_clr = 1'b0;
      misr_en  = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               cnt_d    = 16'h0000;
               lfsr_d   = SEED_EFF;
               done_d   = 1'b0;
               pass_d   = 1'b0;
               misr_clr = 1'b1;
               if (INIT_CYCLES != 0) begin
                  state_d = ST_INIT;
                  vec_d   = INIT_VEC;
               end else if (PATTERNS != 0) begin
                  state_d = ST_RUN;
                  vec_d   = SEED_EFF[3:0];
               end else begin
                  state_d = ST_COMPARE;
                  vec_d   = 4'b0000;
               end
            end
         end
         ST_INIT: begin
            if (cnt_q == INIT_LAST) begin
               cnt_d = 16'h0000;
               if (PATTERNS != 0) begin
                  state_d = ST_RUN;
                  vec_d   = lfsr_q[3:0];
               end else begin
                  state_d = ST_COMPARE;
                  vec_d   = 4'b0000;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         ST_RUN: begin
            // G17 reflects vec_q this cycle; the next vector comes from the advanced LFSR.
            misr_en = 1'b1;
            lfsr_d  = lfsr_next(lfsr_q);
            if (cnt_q == PAT_LAST) begin
               cnt_d   = 16'h0000;
               state_d = ST_COMPARE;
               vec_d   = 4'b0000;
            end else begin
               cnt_d = cnt_q + 16'd1;
               vec_d = lfsr_d[3:0];
            end
         end
         ST_COMPARE: begin
            pass_d  = (misr_sig == GOLDEN);
            done_d  = 1'b1;
            state_d = ST_DONE;
            vec_d   = 4'b0000;
         end
         default: begin
            state_d = ST_IDLE;
            vec_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         cnt_q   <= 16'h0000;
         lfsr_q  <= LFSR_SEED;
         vec_q   <= 4'b0000;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
         vec_q   <= vec_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   s27_bist_misr u_misr (
      .clk_sys (CK),
      .rst     (RST),
      .clr     (misr_clr),
      .en      (misr_en),
      .din     (G17),
      .sig     (misr_sig)
   );

   assign G0        = vec_q[0];
   assign G1        = vec_q[1];
   assign G2        = vec_q[2];
   assign G3        = vec_q[3];
   assign BUSY      = (state_q == ST_INIT) || (state_q == ST_RUN) || (state_q == ST_COMPARE);
   assign DONE      = done_q;
   assign PASS      = pass_q;
   assign SIGNATURE = misr_sig;

endmodule
